lcd_cmd_seq: RTL and testbench

Command/image sequencer sitting directly upstream of `lcd_ctrl`. It holds a programmable 6x6 8-bit image and a list of up to 30 3-bit commands. On `start` it replays them into `lcd_ctrl` over the `cmd`/`cmd_valid`/`datain`/`busy` handshake. Loading is done by a host or bench; the block frees the system from hand-driving the LCD controller protocol.

---
 rtl/lcd_cmd_seq_if.sv | 21 ++
 rtl/lcd_cmd_seq.sv | 149 ++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_seq_if.sv
// Command/pixel handshake between the sequencer (master) and lcd_ctrl (slave).
interface lcd_cmd_seq_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;

  modport master (
    output cmd,
    output cmd_valid,
    output datain,
    input  busy
  );

  modport slave (
    input  cmd,
    input  cmd_valid,
    input  datain,
    output busy
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Replays a programmed command list, and a 6x6 image for every load command,
// into lcd_ctrl. All outputs are registered; the next-output logic looks at the
// next state so that outputs line up with the state they belong to.
module lcd_cmd_seq #(
  parameter int unsigned N_PIX  = 36,
  parameter int unsigned N_CMD  = 30,
  parameter int unsigned PIX_AW = 6,
  parameter int unsigned CMD_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic              prog_sel,
  input  logic [PIX_AW-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic [CMD_AW-1:0] cmd_count,
  input  logic              start,
  lcd_cmd_seq_if.master     lcd,
  output logic              running,
  output logic              done,
  output logic [CMD_AW-1:0] cmd_idx
);

  localparam logic [PIX_AW-1:0] PixLast = PIX_AW'(N_PIX - 1);
  localparam logic [PIX_AW-1:0] PixEnd  = PIX_AW'(N_PIX);
  localparam logic [PIX_AW-1:0] PixOne  = PIX_AW'(1);
  localparam logic [CMD_AW-1:0] CmdMax  = CMD_AW'(N_CMD);
  localparam logic [CMD_AW-1:0] CmdOne  = CMD_AW'(1);
  localparam logic [2:0]        CmdLoad = 3'h1;

  typedef enum logic [2:0] {StIdle, StIssue, StLoad, StWait, StDone} state_e;

  logic [7:0] img_mem [N_PIX];
  logic [2:0] cmd_mem [N_CMD];

  state_e            state_q, state_d;
  logic [CMD_AW-1:0] idx_q, idx_d;
  logic [CMD_AW-1:0] count_q, count_d;
  logic [PIX_AW-1:0] pix_q, pix_d;
  logic              first_q, first_d;   // first WAIT cycle: busy not yet meaningful

  logic [2:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        datain_q, datain_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  // Host programming port; memories are not reset and are frozen during a replay.
  always_ff @(posedge clk) begin
    if (prog_we && !running_q) begin
      if (!prog_sel) begin
        if (prog_addr < PixEnd) img_mem[prog_addr] <= prog_data;
      end else if (prog_addr[CMD_AW-1:0] < CmdMax) begin
        cmd_mem[prog_addr[CMD_AW-1:0]] <= prog_data[2:0];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      count_q     <= '0;
      pix_q       <= '0;
      first_q     <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      datain_q    <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      pix_q       <= pix_d;
      first_q     <= first_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      datain_q    <= datain_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  // Next-state: walk the command list, stream pixels on load, honour busy in WAIT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    pix_d   = pix_q;
    first_d = first_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = (cmd_count > CmdMax) ? CmdMax : cmd_count;
          idx_d   = '0;
          state_d = (cmd_count == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        pix_d   = '0;
        first_d = 1'b1;
        // cmd_q already holds cmd_mem[idx_q] for this issue cycle.
        state_d = (cmd_q == CmdLoad) ? StLoad : StWait;
      end
      StLoad: begin
        if (pix_q == PixLast) state_d = StWait;
        else                  pix_d   = pix_q + PixOne;
      end
      StWait: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!lcd.busy) begin
          if (idx_q == count_q - CmdOne) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + CmdOne;
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next outputs, derived from the state being entered.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    datain_d    = '0;
    running_d   = (state_d == StIssue) || (state_d == StLoad) || (state_d == StWait);
    done_d      = (state_d == StDone);
    if (state_d == StIssue) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_mem[idx_d];
    end
    if (state_d == StLoad) datain_d = img_mem[pix_d];
  end

  assign lcd.cmd       = cmd_q;
  assign lcd.cmd_valid = cmd_valid_q;
  assign lcd.datain    = datain_q;
  assign running       = running_q;
  assign done          = done_q;
  assign cmd_idx       = idx_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed + randomized bench for lcd_cmd_seq. A small lcd_ctrl-like busy model
// drives back-pressure; expected streams are built from a plain array model.
module tb_lcd_cmd_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we, prog_sel;
  logic [5:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] cmd_count;
  logic       start;
  logic       running, done;
  logic [4:0] cmd_idx;

  lcd_cmd_seq_if sif ();

  lcd_cmd_seq u_dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_sel  (prog_sel),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cmd_count (cmd_count),
    .start     (start),
    .lcd       (sif),
    .running   (running),
    .done      (done),
    .cmd_idx   (cmd_idx)
  );

  always #5 clk = ~clk;

  // Reference memories.
  logic [7:0] img_m [36];
  logic [2:0] cmd_m [30];

  int n_checks = 0;
  int n_fail   = 0;

  // Observation state.
  int         cyc = 0;
  int         bcnt = 0;
  int         busy_extra = 0;
  int         pix_left = 0;
  logic [2:0] obs_cmd[$];
  logic [4:0] obs_idx[$];
  int         strobe_cyc[$];
  logic [7:0] obs_pix[$];
  int         done_cnt, done_cyc, viol_busy, viol_dat, running_ticks;
  logic       done_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_cmd.delete(); obs_idx.delete(); strobe_cyc.delete(); obs_pix.delete();
    done_cnt = 0; done_cyc = -1; viol_busy = 0; viol_dat = 0; running_ticks = 0;
    done_busy = 1'b0; pix_left = 0; bcnt = 0; sif.busy = 1'b0;
  endtask

  // One clock: sample on the falling edge, then update the busy model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sif.cmd_valid === 1'b1) begin
      if (sif.busy) viol_busy++;
      obs_cmd.push_back(sif.cmd);
      obs_idx.push_back(cmd_idx);
      strobe_cyc.push_back(cyc);
    end
    if (pix_left > 0) begin
      obs_pix.push_back(sif.datain);
      pix_left--;
    end else if (sif.datain !== 8'h00) begin
      viol_dat++;
    end
    if (sif.cmd_valid === 1'b1 && sif.cmd == 3'h1) pix_left = 36;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = sif.busy;
    end
    if (running === 1'b1) running_ticks++;
    if (sif.cmd_valid === 1'b1)
      bcnt = ((sif.cmd == 3'h1) ? 37 : 0) +
             ((busy_extra < 0) ? int'($urandom_range(0, 12)) : busy_extra);
    sif.busy = (bcnt > 0);
    if (bcnt > 0) bcnt--;
  endtask

  task automatic prog(input bit sel, input int addr, input int data);
    logic [5:0] a;
    logic [7:0] d;
    a = 6'(addr);
    d = 8'(data);
    prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    if (!sel) begin
      if (a < 6'd36) img_m[a] = d;
    end else if (a[4:0] < 5'd30) begin
      cmd_m[a[4:0]] = d[2:0];
    end
  endtask

  // Start a replay of cnt commands and check the resulting stream.
  // bext: fixed extra busy cycles per command, or -1 for random.
  // inj: loop cycle at which to pulse start and prog_we (ignored mid-run), -1 for none.
  task automatic run_list(input string tag, input int cnt, input int bext, input int inj,
                          input bit inj_sel);
    int         n, start_cyc, exp_done, gap_bad, pix_bad, need, a, last;
    logic [7:0] exp_pix[$];
    clear_obs();
    busy_extra = bext;
    n = (cnt > 30) ? 30 : cnt;
    start = 1'b1; cmd_count = 5'(cnt); start_cyc = cyc;
    tick();
    start = 1'b0; cmd_count = 5'($urandom_range(0, 31));
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      if (k == inj) begin
        start = 1'b1; prog_we = 1'b1; prog_sel = inj_sel;
        if (!inj_sel) begin
          a = int'($urandom_range(0, 35));
          prog_addr = 6'(a); prog_data = ~img_m[a];
        end else begin
          a = int'($urandom_range(0, 29));
          prog_addr = 6'(a); prog_data = {5'b0, ~cmd_m[a]};
        end
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      tick();
    end
    start = 1'b0; prog_we = 1'b0;
    repeat (4) tick();

    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " strobes"}, obs_cmd.size(), n);
    for (int i = 0; i < n && i < obs_cmd.size(); i++) begin
      chk($sformatf("%s cmd[%0d]", tag, i), obs_cmd[i], cmd_m[i]);
      chk($sformatf("%s idx[%0d]", tag, i), obs_idx[i], i);
    end
    for (int i = 0; i < n; i++)
      if (cmd_m[i] == 3'h1) for (int p = 0; p < 36; p++) exp_pix.push_back(img_m[p]);
    chk({tag, " pixel count"}, obs_pix.size(), exp_pix.size());
    pix_bad = 0;
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
      if (obs_pix[i] !== exp_pix[i]) pix_bad++;
    chk({tag, " pixel mismatches"}, pix_bad, 0);

    // Minimum spacing: issue + wait + wait, plus 36 pixel cycles for a load.
    gap_bad = 0;
    for (int i = 1; i < obs_cmd.size() && i < n; i++) begin
      need = (cmd_m[i-1] == 3'h1) ? 39 : 3;
      if (strobe_cyc[i] - strobe_cyc[i-1] < need) gap_bad++;
    end
    if (n > 0 && obs_cmd.size() > 0) begin
      chk({tag, " first strobe cycle"}, strobe_cyc[0], start_cyc + 1);
      last = obs_cmd.size() - 1;
      need = (cmd_m[last < 30 ? last : 29] == 3'h1) ? 39 : 3;
      if (done_cyc - strobe_cyc[last] < need) gap_bad++;
    end
    chk({tag, " spacing violations"}, gap_bad, 0);

    exp_done = start_cyc + 1;
    for (int i = 0; i < n; i++) exp_done += (cmd_m[i] == 3'h1) ? 39 : 3;
    if (bext == 0) chk({tag, " done cycle"}, done_cyc, exp_done);
    chk({tag, " strobe while busy"}, viol_busy, 0);
    chk({tag, " stray datain"}, viol_dat, 0);
    chk({tag, " busy at done"}, done_busy, 0);
    chk({tag, " running cycles"}, running_ticks, (n > 0) ? done_cyc - start_cyc - 1 : 0);
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_data = '0;
    cmd_count = '0; start = 1'b0; sif.busy = 1'b0;
    repeat (3) tick();
    chk("reset cmd", sif.cmd, 0);
    chk("reset cmd_valid", sif.cmd_valid, 0);
    chk("reset datain", sif.datain, 0);
    chk("reset running", running, 0);
    chk("reset done", done, 0);
    chk("reset cmd_idx", cmd_idx, 0);
    reset = 1'b0;
    tick();

    // Program and single load.
    for (int k = 0; k < 36; k++) prog(1'b0, k, k + 16);
    prog(1'b1, 0, 1);
    run_list("single", 1, 0, -1, 1'b0);

    // Busy back-pressure.
    prog(1'b1, 0, 1); prog(1'b1, 1, 4); prog(1'b1, 2, 6); prog(1'b1, 3, 0);
    run_list("backpressure", 4, 20, -1, 1'b0);

    // Random image and list; out-of-range writes must be dropped.
    for (int k = 0; k < 36; k++) prog(1'b0, k, int'($urandom_range(0, 255)));
    for (int k = 0; k < 30; k++) prog(1'b1, k, int'($urandom_range(0, 255)));
    prog(1'b1, 0, 1);
    prog(1'b0, int'($urandom_range(36, 63)), int'($urandom_range(0, 255)));
    prog(1'b1, 30, 7);
    prog(1'b1, 31, 7);
    run_list("clamp31", 31, -1, -1, 1'b0);
    run_list("random", int'($urandom_range(1, 30)), 0, -1, 1'b0);
    run_list("zero", 0, 0, -1, 1'b0);

    // Reset in the middle of a pixel stream.
    clear_obs();
    busy_extra = 0;
    start = 1'b1; cmd_count = 5'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && obs_pix.size() < 18; k++) tick();
    chk("midload reached pixel 17", obs_pix.size(), 18);
    if (obs_pix.size() == 18) chk("midload pixel 17", obs_pix[17], img_m[17]);
    reset = 1'b1; pix_left = 0; bcnt = 0; sif.busy = 1'b0;
    tick();
    chk("midload datain", sif.datain, 0);
    chk("midload running", running, 0);
    chk("midload cmd_valid", sif.cmd_valid, 0);
    chk("midload done", done, 0);
    chk("midload cmd_idx", cmd_idx, 0);
    reset = 1'b0;
    tick();
    run_list("rerun", 5, -1, -1, 1'b0);

    // start / prog_we while running have no effect; readback shows memory intact.
    run_list("ignore_img", 30, -1, 12, 1'b0);
    run_list("ignore_cmd", 30, -1, 12, 1'b1);
    run_list("readback", 30, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
